// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types plus the arbiter state encoding and default limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGNT   = 2'd1,
      DGNT   = 2'd2,
      SCFAIL = 2'd3
   } arb_state_t;

   localparam int ARB_TIMEOUT    = 15;
   localparam int ARB_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arbiter_link_reg.sv
// LL/SC link register: remembers the last LL address and checks SC against it.
// Latency: updates one cycle after the completing access; match is combinational.
// Backpressure: none, driven purely by completion strobes from the arbiter.
module link_reg
   import cpu_types_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  ll_done,
   input  logic  sc_done,
   input  logic  sw_done,
   input  word_t addr,
   output logic  link_valid,
   output logic  sc_ok
);

   logic  link_valid_q, link_valid_d;
   word_t link_addr_q, link_addr_d;

   // Next link state: LL arms, any SC disarms, a plain store to the linked word disarms.
   always_comb begin
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      if (ll_done) begin
         link_valid_d = 1'b1;
         link_addr_d  = addr;
      end else if (sc_done) begin
         link_valid_d = 1'b0;
      end else if (sw_done && (addr == link_addr_q)) begin
         link_valid_d = 1'b0;
      end
   end

   // Link state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end

   assign link_valid = link_valid_q;
   assign sc_ok      = link_valid_q && (link_addr_q == addr);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data ports onto one RAM, with LL/SC and timeout abort.
// Latency: minimum 2 cycles request->hit (IDLE decision, then grant with ACCESS).
// Backpressure: requesters hold requests until hit; RAM stalls via ramstate != ACCESS.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT    = ARB_TIMEOUT,
   parameter int STARVE_MAX = ARB_STARVE_MAX
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        ihit,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic        datomic,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        mem_err
);

   localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [2:0]     STARVE_LIM = 3'(STARVE_MAX);

   arb_state_t    state_q, state_d;
   logic [2:0]    starve_cnt_q, starve_cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          mem_err_q, mem_err_d;

   ramstate_t rs;
   logic      d_pend, is_sc, abort, sc_ok, link_valid;
   logic      ll_done, sc_done, sw_done;

   assign rs     = ramstate_t'(ramstate);
   assign d_pend = dREN || dWEN;
   assign is_sc  = dWEN && datomic;
   // A waiting grant gives up on an explicit RAM error or when its cycle budget runs out.
   assign abort  = (rs == ERROR) || (tmo_q >= TMO_LAST);

   link_reg u_link (
      .clk        (CLK),
      .rst_n      (nRST),
      .ll_done    (ll_done),
      .sc_done    (sc_done),
      .sw_done    (sw_done),
      .addr       (daddr),
      .link_valid (link_valid),
      .sc_ok      (sc_ok)
   );

   // Next-state, counters and all port muxing; everything defaults to idle/zero.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      tmo_d        = tmo_q;
      mem_err_d    = mem_err_q;
      ihit         = 1'b0;
      iload        = '0;
      dhit         = 1'b0;
      dload        = '0;
      ramREN       = 1'b0;
      ramWEN       = 1'b0;
      ramaddr      = '0;
      ramstore     = '0;
      ll_done      = 1'b0;
      sc_done      = 1'b0;
      sw_done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!iREN) starve_cnt_d = '0;
            if (d_pend && ((starve_cnt_q < STARVE_LIM) || !iREN)) begin
               tmo_d = '0;
               if (iREN && (starve_cnt_q != 3'd7)) starve_cnt_d = starve_cnt_q + 3'd1;
               state_d = (is_sc && !sc_ok) ? SCFAIL : DGNT;
            end else if (iREN) begin
               tmo_d        = '0;
               starve_cnt_d = '0;
               state_d      = IGNT;
            end
         end
         IGNT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (rs == ACCESS) begin
               ihit    = 1'b1;
               iload   = ramload;
               state_d = IDLE;
            end else if (abort) begin
               mem_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DGNT: begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (rs == ACCESS) begin
               dhit    = 1'b1;
               dload   = is_sc ? 32'd1 : ramload;
               ll_done = dREN && datomic;
               sc_done = is_sc;
               sw_done = dWEN && !datomic;
               state_d = IDLE;
            end else if (abort) begin
               mem_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         SCFAIL: begin
            dhit    = 1'b1;
            sc_done = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and sticky error registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         tmo_q        <= '0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         tmo_q        <= tmo_d;
         mem_err_q    <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, starvation limit, LL/SC, timeout/error, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN, datomic;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        ihit, dhit, ramREN, ramWEN, mem_err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int n_assert = 0;
   int n_fail   = 0;

   mem_arbiter #(.TIMEOUT(15), .STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
      .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; datomic = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = BUSY;
      #2;
      chk("rst_state",  32'(dut.state_q), 32'(IDLE));
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      chk("rst_hits",   32'({ihit, dhit}), 32'd0);
      chk("rst_err",    32'(mem_err), 32'd0);
      next_cycle();
      nRST = 1'b1;
      next_cycle();

      // Instruction fetch, ACCESS on the second grant cycle.
      iREN = 1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'h8C010004;
      #2;
      chk("if_c1_ramREN", 32'(ramREN), 32'd0);
      chk("if_c1_ihit",   32'(ihit), 32'd0);
      next_cycle(); #2;
      chk("if_c2_ramREN", 32'(ramREN), 32'd1);
      chk("if_c2_addr",   ramaddr, 32'h40);
      chk("if_c2_ihit",   32'(ihit), 32'd0);
      next_cycle();
      ramstate = ACCESS;
      #2;
      chk("if_c3_ihit",   32'(ihit), 32'd1);
      chk("if_c3_iload",  iload, 32'h8C010004);
      chk("if_c3_ramREN", 32'(ramREN), 32'd1);
      next_cycle();
      iREN = 0; ramstate = FREE;
      #2;
      chk("if_c4_ihit",   32'(ihit), 32'd0);
      chk("if_c4_ramREN", 32'(ramREN), 32'd0);
      chk("if_c4_iload",  iload, 32'd0);

      // Both ports requesting: D first, I after exactly four D grants.
      next_cycle();
      iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h200; ramload = 32'h11; ramstate = ACCESS;
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) next_cycle();
         #2;
         chk($sformatf("starve_c%0d_dhit", c), 32'(dhit), 32'((c == 2) || (c == 4) || (c == 6) || (c == 8)));
         chk($sformatf("starve_c%0d_ihit", c), 32'(ihit), 32'(c == 10));
         if (c == 2) begin
            chk("starve_daddr", ramaddr, 32'h200);
            chk("starve_dload", dload, 32'h11);
         end
         if (c == 10) chk("starve_iaddr", ramaddr, 32'h44);
      end
      next_cycle();
      iREN = 0; dREN = 0;

      // LL, successful SC, then a second SC that must fail.
      next_cycle();
      dREN = 1; datomic = 1; daddr = 32'h100; ramload = 32'h77;
      next_cycle(); #2;
      chk("ll_dhit",  32'(dhit), 32'd1);
      chk("ll_dload", dload, 32'h77);
      next_cycle();
      dREN = 0; dWEN = 1; datomic = 1; dstore = 32'd5;
      next_cycle(); #2;
      chk("sc1_ramWEN",   32'(ramWEN), 32'd1);
      chk("sc1_ramstore", ramstore, 32'd5);
      chk("sc1_dhit",     32'(dhit), 32'd1);
      chk("sc1_dload",    dload, 32'd1);
      next_cycle(); #2;
      chk("sc2_idle_ramWEN", 32'(ramWEN), 32'd0);
      chk("sc2_idle_dhit",   32'(dhit), 32'd0);
      next_cycle(); #2;
      chk("sc2_state",  32'(dut.state_q), 32'(SCFAIL));
      chk("sc2_dhit",   32'(dhit), 32'd1);
      chk("sc2_dload",  dload, 32'd0);
      chk("sc2_ramWEN", 32'(ramWEN), 32'd0);
      next_cycle();
      dWEN = 0; datomic = 0;
      #2;
      chk("sc2_after_ramWEN", 32'(ramWEN), 32'd0);

      // LL, plain store to the same word, then SC must fail.
      next_cycle();
      dREN = 1; datomic = 1; daddr = 32'h100;
      next_cycle(); #2;
      chk("ll2_dhit", 32'(dhit), 32'd1);
      next_cycle();
      dREN = 0; dWEN = 1; datomic = 0; dstore = 32'd9;
      next_cycle(); #2;
      chk("sw_ramWEN", 32'(ramWEN), 32'd1);
      chk("sw_dhit",   32'(dhit), 32'd1);
      next_cycle();
      datomic = 1; dstore = 32'd6;
      next_cycle(); #2;
      chk("sc3_dhit",   32'(dhit), 32'd1);
      chk("sc3_dload",  dload, 32'd0);
      chk("sc3_ramWEN", 32'(ramWEN), 32'd0);
      next_cycle();
      dWEN = 0; datomic = 0;

      // RAM stuck BUSY: abort after 15 grant cycles, no hit.
      next_cycle();
      iREN = 1; iaddr = 32'h80; ramstate = BUSY;
      for (int c = 2; c <= 16; c++) begin
         next_cycle(); #2;
         chk($sformatf("tmo_c%0d_ihit", c), 32'(ihit), 32'd0);
         chk($sformatf("tmo_c%0d_state", c), 32'(dut.state_q), 32'(IGNT));
      end
      chk("tmo_err_before", 32'(mem_err), 32'd0);
      next_cycle();
      iREN = 0;
      #2;
      chk("tmo_err",   32'(mem_err), 32'd1);
      chk("tmo_state", 32'(dut.state_q), 32'(IDLE));
      chk("tmo_ihit",  32'(ihit), 32'd0);

      // Reset during a data grant.
      next_cycle();
      dREN = 1; datomic = 1; daddr = 32'h300; ramstate = ACCESS;
      next_cycle(); #2;
      chk("rl_dhit", 32'(dhit), 32'd1);
      next_cycle();
      datomic = 0; daddr = 32'h304; ramstate = BUSY;
      next_cycle(); #2;
      chk("rg_ramREN", 32'(ramREN), 32'd1);
      chk("rg_link",   32'(dut.u_link.link_valid_q), 32'd1);
      nRST = 0;
      #1;
      ramstate = ACCESS; ramload = 32'hABCD;
      #1;
      chk("rg_rst_ramREN", 32'(ramREN), 32'd0);
      chk("rg_rst_addr",   ramaddr, 32'd0);
      chk("rg_rst_dhit",   32'(dhit), 32'd0);
      chk("rg_rst_err",    32'(mem_err), 32'd0);
      chk("rg_rst_link",   32'(dut.u_link.link_valid_q), 32'd0);
      chk("rg_rst_state",  32'(dut.state_q), 32'(IDLE));
      next_cycle();
      nRST = 1;
      #2;
      chk("rg_rel_dhit",  32'(dhit), 32'd0);
      chk("rg_rel_state", 32'(dut.state_q), 32'(IDLE));
      next_cycle(); #2;
      chk("rg_svc_dhit",  32'(dhit), 32'd1);
      chk("rg_svc_dload", dload, 32'hABCD);
      next_cycle();
      dREN = 0;

      // RAM ERROR: immediate abort on the first grant cycle.
      next_cycle();
      dREN = 1; daddr = 32'h400; ramstate = ERROR;
      next_cycle(); #2;
      chk("er_dhit",  32'(dhit), 32'd0);
      chk("er_state", 32'(dut.state_q), 32'(DGNT));
      chk("er_err0",  32'(mem_err), 32'd0);
      next_cycle();
      dREN = 0;
      #2;
      chk("er_err1",   32'(mem_err), 32'd1);
      chk("er_state2", 32'(dut.state_q), 32'(IDLE));
      chk("er_dhit2",  32'(dhit), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles a grant may wait for ramstate ACCESS before aborting.
REQ-002 Parameter STARVE_MAX, default 4: consecutive D grants allowed while I is pending.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  system clock, rising edge.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 iREN  in  1  instruction read request, held until ihit.
REQ-007 iaddr  in  32  instruction word address.
REQ-008 ihit  out  1  instruction read complete, one-cycle pulse.
REQ-009 iload  out  32  instruction data, valid while ihit.
REQ-010 dREN  in  1  data read request, held until dhit.
REQ-011 dWEN  in  1  data write request, held until dhit; dREN and dWEN are never both high.
REQ-012 datomic  in  1  qualifies dREN as LL and dWEN as SC.
REQ-013 daddr  in  32  data word address.
REQ-014 dstore  in  32  write data.
REQ-015 dhit  out  1  data access complete, one-cycle pulse.
REQ-016 dload  out  32  read data or SC result, valid while dhit.
REQ-017 ramREN  out  1  RAM read strobe.
REQ-018 ramWEN  out  1  RAM write strobe.
REQ-019 ramaddr  out  32  RAM address.
REQ-020 ramstore  out  32  RAM write data.
REQ-021 ramload  in  32  RAM read data.
REQ-022 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
REQ-023 mem_err  out  1  sticky flag: timeout or ERROR seen.

Function
REQ-024 FSM states: IDLE, IGNT, DGNT, SCFAIL.
- IDLE: D pending and (starve_cnt < STARVE_MAX or !iREN) -> DGNT.
- Otherwise, I pending -> IGNT.
- An SC whose link check fails -> SCFAIL instead of DGNT.
REQ-025 RAM drive by state:
- IGNT: ramREN=1, ramaddr=iaddr.
- DGNT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
- IDLE and SCFAIL: all RAM strobes 0.
REQ-026 Completion: in IGNT/DGNT, the cycle ramstate==ACCESS, assert ihit/dhit combinationally; iload/dload=ramload (SC success: dload=1); next state IDLE.
REQ-027 Minimum latency request->hit is 2 cycles (IDLE, then the grant cycle with ACCESS); no back-to-back grant without passing through IDLE.
REQ-028 SCFAIL: dhit=1, dload=0, no RAM write, next state IDLE; occupies 1 cycle.
REQ-029 starve_cnt (3 bits, saturating):
- +1 on each D grant while iREN=1.
- Cleared on an I grant, or when iREN=0 in IDLE.
REQ-030 Timeout counter:
- Cleared on grant entry; increments each grant cycle without ACCESS.
- On reaching TIMEOUT or on ramstate==ERROR: set mem_err, return to IDLE, no hit.
- The requester retries by still holding its request.
REQ-031 Link register: link_valid, link_addr[31:0].
- LL completion sets link_valid=1, link_addr=daddr.
- SC (success or fail) clears link_valid.
- Plain write completion with daddr==link_addr clears link_valid.
REQ-032 SC succeeds iff link_valid and link_addr==daddr at IDLE decision.
REQ-033 Requests deasserting mid-grant (illegal) -> FSM completes or times out normally; no lockup.
REQ-034 Outputs not listed as driven in the current state are 0.

Reset
REQ-035 On nRST low, asynchronously:
- state=IDLE; starve_cnt=0; timeout counter=0.
- link_valid=0, link_addr=0; mem_err=0.
- All RAM strobes, hits and data outputs read 0.
REQ-036 Reset mid-grant aborts the access with no hit; the first grant after release starts from IDLE.

Structure
REQ-037 ramstate_t and word_t come from cpu_types_pkg; the arbiter state enum and default TIMEOUT/STARVE_MAX constants are added to cpu_types_pkg.
REQ-038 One sub-module, link_reg, holds LL/SC link state and the match compare; the FSM, counters and muxing stay in mem_arbiter.

Verification
REQ-039 iREN only, iaddr=0x40, ACCESS on the 2nd grant cycle, ramload=0x8C010004 -> ihit pulse at cycle 3 with iload=0x8C010004, ramREN high 2 cycles.
REQ-040 iREN and dREN together, ACCESS immediate -> D served first, then I; with dREN held continuously, I is granted after exactly 4 D grants.
REQ-041 LL 0x100 then SC 0x100 with dstore=5 -> ramWEN with ramstore=5, dhit with dload=1; a second SC to 0x100 -> SCFAIL, dload=0, ramWEN never high.
REQ-042 LL 0x100, plain SW to 0x100, SC to 0x100 -> SC fails, dload=0.
REQ-043 ramstate held BUSY -> after 15 grant cycles mem_err=1, FSM in IDLE, no hit; ramstate ERROR gives the same result immediately.
REQ-044 nRST pulsed low during DGNT -> outputs 0 the same cycle, no dhit, link_valid=0, normal service after release.
